ip_layer_ctrl: RTL and testbench

- Sequencer for the inner-product (FC) input reader and the MS-wide MAC array.
- For each layer 0..NUM_LAYERS-1 and each output-neuron batch it issues a neuron-start pulse, then drives the reader's BRAM read enable for exactly the layer's input length.
- It then waits for the MAC array to finish and advances batch or layer until the whole FC stack is done.
- Sits between the top-level FC start and the input reader / MAC array.

---
 rtl/ip_layer_ctrl_if.sv | 28 ++
 rtl/ip_layer_ctrl.sv | 154 +++++++++++++++
 tb/tb_ip_layer_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_layer_ctrl_if.sv
// Signal bundle between the FC layer sequencer, the input reader and the MAC array.
// slave is the sequencer side; master is the surrounding control/reader side.
interface ip_layer_ctrl_if;
   logic       ip_start_i;
   logic       stall_i;
   logic       switch_block_i;
   logic       acc_done_i;
   logic       rd_bram_start_o;
   logic       ip_oneuron_start_o;
   logic [2:0] cur_layer_index_o;
   logic [7:0] batch_idx_o;
   logic       layer_done_o;
   logic       all_done_o;
   logic       busy_o;
   logic       err_o;

   modport slave (
      input  ip_start_i, stall_i, switch_block_i, acc_done_i,
      output rd_bram_start_o, ip_oneuron_start_o, cur_layer_index_o, batch_idx_o,
             layer_done_o, all_done_o, busy_o, err_o
   );

   modport master (
      output ip_start_i, stall_i, switch_block_i, acc_done_i,
      input  rd_bram_start_o, ip_oneuron_start_o, cur_layer_index_o, batch_idx_o,
             layer_done_o, all_done_o, busy_o, err_o
   );
endinterface

// File: rtl/ip_layer_ctrl.sv
// Sequencer for the FC input reader and MAC array: walks every layer and output batch,
// issuing a neuron-start pulse, the layer's input reads, then waiting for the MAC drain.
module ip_layer_ctrl #(
   parameter int unsigned NUM_LAYERS = 6,
   parameter int unsigned NB0        = 128,
   parameter int unsigned NB1        = 128,
   parameter int unsigned NB2        = 128,
   parameter int unsigned NB3        = 128,
   parameter int unsigned NB4        = 128,
   parameter int unsigned NB5        = 32,
   parameter int unsigned DRAIN_MAX  = 255
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   ip_layer_ctrl_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StStart, StRead, StCheck, StDrain, StNext} state_e;

   state_e      state_q;
   logic [14:0] rd_cnt_q;
   logic [7:0]  drain_cnt_q;
   logic [7:0]  batch_q;
   logic [2:0]  layer_q;
   logic        oneuron_q;
   logic        layer_done_q;
   logic        all_done_q;
   logic        busy_q;
   logic        err_q;

   logic [14:0] rd_last;
   logic [7:0]  batch_last;
   logic        rd_en;
   logic        last_batch;
   logic        last_layer;
   logic        drain_expired;

   // Index of the final read of a batch (reads per batch minus one).
   always_comb begin
      case (layer_q)
         3'd0:    rd_last = 15'd25087;
         3'd1:    rd_last = 15'd255;
         3'd2:    rd_last = 15'd4095;
         3'd3:    rd_last = 15'd255;
         3'd4:    rd_last = 15'd4095;
         3'd5:    rd_last = 15'd999;
         default: rd_last = 15'd0;
      endcase
   end

   always_comb begin
      case (layer_q)
         3'd0:    batch_last = 8'(NB0 - 1);
         3'd1:    batch_last = 8'(NB1 - 1);
         3'd2:    batch_last = 8'(NB2 - 1);
         3'd3:    batch_last = 8'(NB3 - 1);
         3'd4:    batch_last = 8'(NB4 - 1);
         3'd5:    batch_last = 8'(NB5 - 1);
         default: batch_last = 8'd0;
      endcase
   end

   // Read enable is a pure decode of the state so an async reset drops it at once.
   assign rd_en         = (state_q == StRead) && !bus.stall_i;
   assign last_batch    = (batch_q == batch_last);
   assign last_layer    = (layer_q == 3'(NUM_LAYERS - 1));
   assign drain_expired = (drain_cnt_q == 8'(DRAIN_MAX - 1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= StIdle;
         rd_cnt_q     <= '0;
         drain_cnt_q  <= '0;
         batch_q      <= '0;
         layer_q      <= '0;
         oneuron_q    <= 1'b0;
         layer_done_q <= 1'b0;
         all_done_q   <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         oneuron_q    <= 1'b0;
         layer_done_q <= 1'b0;
         all_done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.ip_start_i) begin
                  layer_q   <= '0;
                  batch_q   <= '0;
                  oneuron_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= StStart;
               end
            end
            StStart: begin
               rd_cnt_q <= '0;
               state_q  <= StRead;
            end
            StRead: begin
               if (bus.switch_block_i) err_q <= 1'b1;
               if (rd_en) begin
                  rd_cnt_q <= rd_cnt_q + 15'd1;
                  if (rd_cnt_q == rd_last) state_q <= StCheck;
               end
            end
            StCheck: begin
               // The reader must flag end-of-block exactly one cycle after its last read.
               if (!bus.switch_block_i) err_q <= 1'b1;
               drain_cnt_q <= '0;
               state_q     <= StDrain;
            end
            StDrain: begin
               drain_cnt_q <= drain_cnt_q + 8'd1;
               if (bus.acc_done_i || drain_expired) begin
                  if (!bus.acc_done_i) err_q <= 1'b1;
                  // Done pulses are set here so they are high during the NEXT cycle itself.
                  layer_done_q <= last_batch;
                  all_done_q   <= last_batch && last_layer;
                  state_q      <= StNext;
               end
            end
            StNext: begin
               if (!last_batch) begin
                  batch_q   <= batch_q + 8'd1;
                  oneuron_q <= 1'b1;
                  state_q   <= StStart;
               end else begin
                  batch_q <= '0;
                  if (!last_layer) begin
                     layer_q   <= layer_q + 3'd1;
                     oneuron_q <= 1'b1;
                     state_q   <= StStart;
                  end else begin
                     layer_q <= '0;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.rd_bram_start_o    = rd_en;
   assign bus.ip_oneuron_start_o = oneuron_q;
   assign bus.cur_layer_index_o  = layer_q;
   assign bus.batch_idx_o        = batch_q;
   assign bus.layer_done_o       = layer_done_q;
   assign bus.all_done_o         = all_done_q;
   assign bus.busy_o             = busy_q;
   assign bus.err_o              = err_q;

endmodule

// File: tb/tb_ip_layer_ctrl.sv
// Scoreboard bench for ip_layer_ctrl: a reader/MAC stub answers the DUT, a monitor
// pops expected start/read/done events pushed when each run is launched.
module tb_ip_layer_ctrl;
   localparam int NL     = 6;
   localparam int KStart = 0;
   localparam int KReads = 1;
   localparam int KLayer = 2;
   localparam int KAll   = 3;

   typedef struct {
      int kind;
      int a;
      int b;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   ip_layer_ctrl_if bus ();

   ip_layer_ctrl #(
      .NUM_LAYERS(6), .NB0(1), .NB1(1), .NB2(2), .NB3(1), .NB4(1), .NB5(2), .DRAIN_MAX(255)
   ) dut (
      .clk_i (clk),
      .rstn_i(rstn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   int   run_id = 0;

   function automatic int nb_of(int l);
      case (l)
         0: return 1;
         1: return 1;
         2: return 2;
         3: return 1;
         4: return 1;
         5: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int rd_len(int l);
      case (l)
         0: return 25088;
         1: return 256;
         2: return 4096;
         3: return 256;
         4: return 4096;
         5: return 1000;
         default: return 1;
      endcase
   endfunction

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic expect_ev(string name, int kind, int a, int b);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got event %0d/%0d/%0d expected nothing pending", name, kind, a, b);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.a != a || e.b != b) begin
            errors++;
            $display("FAIL %s: got kind %0d a %0d b %0d expected kind %0d a %0d b %0d",
                     name, kind, a, b, e.kind, e.a, e.b);
         end
      end
   endtask

   task automatic push_run();
      for (int l = 0; l < NL; l++) begin
         for (int b = 0; b < nb_of(l); b++) begin
            sb_q.push_back(exp_t'{KStart, l, b});
            sb_q.push_back(exp_t'{KReads, rd_len(l), 0});
            if (b == nb_of(l) - 1) sb_q.push_back(exp_t'{KLayer, l, 0});
            if (b == nb_of(l) - 1 && l == NL - 1) sb_q.push_back(exp_t'{KAll, 0, 0});
         end
      end
   endtask

   // ---------------- monitor ----------------
   int rd_seen = 0;
   int open_layer = 0;
   int open_batch = 0;
   bit batch_open = 0;
   bit idx_moved = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            batch_open = 0;
            rd_seen    = 0;
            idx_moved  = 0;
         end else begin
            if (batch_open && !bus.ip_oneuron_start_o &&
                (int'(bus.cur_layer_index_o) != open_layer ||
                 int'(bus.batch_idx_o) != open_batch)) idx_moved = 1;
            if (batch_open && (bus.ip_oneuron_start_o || bus.layer_done_o)) begin
               expect_ev("batch_reads", KReads, rd_seen, 0);
               check("idx_stable", int'(idx_moved), 0);
               batch_open = 0;
            end
            if (bus.ip_oneuron_start_o) begin
               expect_ev("batch_start", KStart, bus.cur_layer_index_o, bus.batch_idx_o);
               batch_open = 1;
               open_layer = bus.cur_layer_index_o;
               open_batch = bus.batch_idx_o;
               rd_seen    = 0;
               idx_moved  = 0;
            end
            if (bus.rd_bram_start_o) rd_seen++;
            if (bus.layer_done_o) expect_ev("layer_done", KLayer, bus.cur_layer_index_o, 0);
            if (bus.all_done_o) expect_ev("all_done", KAll, 0, 0);
         end
      end
   end

   // ---------------- reader / MAC stub ----------------
   int m_layer = 0;
   int m_batch = 0;
   int rcnt = 0;
   int acc_wait = 0;
   int stall_left = 0;
   bit final_stalled = 0;
   bit chk_pend = 0;
   bit acc_hold = 0;
   int check_cycle = 0;
   int chk_layer = -1;

   initial begin
      bus.stall_i        = 1'b0;
      bus.switch_block_i = 1'b0;
      bus.acc_done_i     = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            m_layer = 0; m_batch = 0; rcnt = 0; acc_wait = 0;
            stall_left = 0; final_stalled = 0; chk_pend = 0;
         end else begin
            if (bus.stall_i) check("read_in_stall", int'(bus.rd_bram_start_o), 0);
            if (bus.rd_bram_start_o) rcnt++;
            chk_pend = bus.rd_bram_start_o && (rcnt == rd_len(m_layer));
            if (run_id == 1 && m_layer == 1 && m_batch == 0 && !chk_pend) begin
               if (bus.rd_bram_start_o && rcnt == 100) stall_left = 10;
               if (rcnt == rd_len(1) - 1 && !final_stalled && stall_left == 0) begin
                  stall_left    = 3;
                  final_stalled = 1;
               end
            end
         end
         @(posedge clk);
         #1;
         bus.switch_block_i = 1'b0;
         bus.acc_done_i     = 1'b0;
         if (chk_pend) begin
            // This cycle is the DUT's CHECK cycle.
            bus.switch_block_i = !(run_id == 2 && m_layer == 0);
            acc_hold    = (run_id == 1 && m_layer == 3);
            acc_wait    = (m_layer == 0) ? 5 : 3;
            check_cycle = cyc;
            chk_layer   = m_layer;
            rcnt        = 0;
            chk_pend    = 0;
            m_batch++;
            if (m_batch == nb_of(m_layer)) begin
               m_batch = 0;
               m_layer = (m_layer == NL - 1) ? 0 : m_layer + 1;
            end
         end else if (acc_wait > 0) begin
            acc_wait--;
            if (acc_wait == 0 && !acc_hold) bus.acc_done_i = 1'b1;
         end
         bus.stall_i = (stall_left > 0);
         if (stall_left > 0) stall_left--;
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      @(posedge clk);
      #1 bus.ip_start_i = 1'b1;
      @(posedge clk);
      #1 bus.ip_start_i = 1'b0;
   endtask

   task automatic check_zero(string tag);
      check({tag, "_rd"}, int'(bus.rd_bram_start_o), 0);
      check({tag, "_oneuron"}, int'(bus.ip_oneuron_start_o), 0);
      check({tag, "_layer"}, int'(bus.cur_layer_index_o), 0);
      check({tag, "_batch"}, int'(bus.batch_idx_o), 0);
      check({tag, "_layer_done"}, int'(bus.layer_done_o), 0);
      check({tag, "_all_done"}, int'(bus.all_done_o), 0);
      check({tag, "_busy"}, int'(bus.busy_o), 0);
      check({tag, "_err"}, int'(bus.err_o), 0);
   endtask

   // sel: 0 err_o, 1 all_done_o
   task automatic wait_for(string name, int sel, int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk);
         if ((sel == 0 && bus.err_o) || (sel == 1 && bus.all_done_o)) ok = 1;
      end
      check({name, "_seen"}, int'(ok), 1);
   endtask

   task automatic reset_mid_cycle(string tag);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1 check_zero(tag);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
   endtask

   initial begin
      bit ok;
      bit found;
      bus.ip_start_i = 1'b0;
      repeat (3) @(posedge clk);
      #2 check_zero("reset");
      @(posedge clk);
      #3 rstn = 1'b1;

      // Run 1: full stack, stall in layer 1, withheld acc_done in layer 3.
      run_id = 1;
      push_run();
      pulse_start();
      repeat (300) @(negedge clk);
      check("busy_running", int'(bus.busy_o), 1);
      check("err_before", int'(bus.err_o), 0);
      pulse_start();
      wait_for("drain_timeout", 0, 40000, ok);
      if (ok) begin
         check("timeout_cycles", cyc - check_cycle, 256);
         check("timeout_layer", chk_layer, 3);
      end
      wait_for("run1_done", 1, 20000, ok);
      @(negedge clk);
      check("busy_after", int'(bus.busy_o), 0);
      check("err_sticky", int'(bus.err_o), 1);
      check("sb_drained", sb_q.size(), 0);

      // Run 2: missing switch_block in layer 0, reset during layer 2 batch 1.
      reset_mid_cycle("reset2");
      run_id = 2;
      push_run();
      pulse_start();
      wait_for("switch_missing", 0, 30000, ok);
      if (ok) begin
         check("switch_err_cycles", cyc - check_cycle, 1);
         check("switch_err_layer", chk_layer, 0);
      end
      found = 0;
      for (int i = 0; i < 10000 && !found; i++) begin
         @(negedge clk);
         if (bus.ip_oneuron_start_o && m_layer == 2 && m_batch == 1) found = 1;
      end
      check("reach_l2b1", int'(found), 1);
      repeat (50) @(negedge clk);
      check("pre_rst_rd", int'(bus.rd_bram_start_o), 1);
      check("pre_rst_layer", int'(bus.cur_layer_index_o), 2);
      check("pre_rst_batch", int'(bus.batch_idx_o), 1);
      check("pre_rst_err", int'(bus.err_o), 1);
      reset_mid_cycle("midrun");

      // Run 3: restart must begin at layer 0, batch 0.
      run_id = 3;
      push_run();
      pulse_start();
      repeat (20) @(negedge clk);
      check("restart_popped", sb_q.size(), 22);
      check("restart_busy", int'(bus.busy_o), 1);
      reset_mid_cycle("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
